// File: rtl/trackball_pkg.sv
// Shared constants and types for the trackball decoder.
//   AXIS_H / AXIS_V   : rd_sel encodings
//   DOUT_*            : bit positions inside the CPU snapshot byte
//   COUNT_W           : width of each axis step counter (LS169 pair emulation)
//   axis_state_t      : per-axis registered state exposed to the read mux
//   pack_dout()       : formats an axis state into the input-port byte
package trackball_pkg;

    localparam logic AXIS_H = 1'b0;
    localparam logic AXIS_V = 1'b1;

    localparam int unsigned DOUT_DIR       = 7;
    localparam int unsigned DOUT_MOVING    = 6;
    localparam int unsigned DOUT_COUNT_LSB = 0;

    localparam int unsigned COUNT_W = 4;

    typedef logic [COUNT_W-1:0] count_t;

    typedef struct packed {
        logic   dir;
        logic   moving;
        count_t count;
    } axis_state_t;

    function automatic logic [7:0] pack_dout(input axis_state_t s);
        logic [7:0] d;
        d                              = '0;
        d[DOUT_DIR]                    = s.dir;
        d[DOUT_MOVING]                 = s.moving;
        d[DOUT_COUNT_LSB +: COUNT_W]   = s.count;
        return d;
    endfunction

endpackage

// File: rtl/trackball_decoder_if.sv
// CPU read bus of the trackball decoder.
//   rd_sel    : 0 = horizontal axis, 1 = vertical axis
//   rd_strobe : single-cycle read request
//   dout      : registered snapshot {dir, moving, 2'b00, count}
// master = CPU input mux side, slave = decoder side.
interface trackball_decoder_if;

    logic       rd_sel;
    logic       rd_strobe;
    logic [7:0] dout;

    modport master (
        output rd_sel,
        output rd_strobe,
        input  dout
    );

    modport slave (
        input  rd_sel,
        input  rd_strobe,
        output dout
    );

endinterface

// File: rtl/trackball_axis.sv
// One trackball axis: synchronises the direction level and step clock, deglitches
// the step clock, detects step edges and drives a 4-bit up/down counter plus an
// idle timer that produces the moving flag.
//   clk, reset   : system clock, synchronous active-high reset
//   warmup       : high while post-reset warmup runs; filter tracks, steps suppressed
//   flip         : cocktail flip, inverts the count direction
//   dir_raw      : asynchronous direction level (1 = negative)
//   step_clk_raw : asynchronous step clock
//   state        : registered {dir, moving, count}
module trackball_axis
    import trackball_pkg::*;
#(
    parameter int unsigned SYNC_STAGES      = 2,
    parameter int unsigned FILTER_LEN       = 4,
    parameter int unsigned IDLE_CYCLES      = 1048576,
    parameter int unsigned COUNT_BOTH_EDGES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        warmup,
    input  logic        flip,
    input  logic        dir_raw,
    input  logic        step_clk_raw,
    output axis_state_t state
);

    localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned IW = $clog2(IDLE_CYCLES + 1);
    localparam logic [FW-1:0] FILT_MAX   = FW'(FILTER_LEN - 1);
    localparam logic [IW-1:0] IDLE_MAX   = IW'(IDLE_CYCLES);
    localparam logic [IW-1:0] IDLE_CLEAR = IW'(IDLE_CYCLES - 1);

    // Dir and clk share the same depth so a level and its step stay aligned.
    logic [SYNC_STAGES-1:0] dir_sync_q;
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic                   dir_s;
    logic                   clk_s;

    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          filt_q, filt_d;
    logic          filt_prev_q;

    logic          step;
    logic          eff_dir;

    count_t        count_q, count_d;
    logic          dir_q, dir_d;
    logic          moving_q, moving_d;
    logic [IW-1:0] idle_q, idle_d;

    assign dir_s = dir_sync_q[SYNC_STAGES-1];
    assign clk_s = clk_sync_q[SYNC_STAGES-1];

    always_comb begin
        filt_cnt_d = filt_cnt_q;
        filt_d     = filt_q;
        if (warmup) begin
            // Follow the input directly so a level already high at reset release
            // is absorbed before steps are enabled.
            filt_d     = clk_s;
            filt_cnt_d = '0;
        end else if (clk_s != filt_q) begin
            if (filt_cnt_q == FILT_MAX) begin
                filt_d     = clk_s;
                filt_cnt_d = '0;
            end else begin
                filt_cnt_d = filt_cnt_q + FW'(1);
            end
        end else begin
            filt_cnt_d = '0;
        end
    end

    assign step    = !warmup && (filt_q != filt_prev_q) &&
                     ((COUNT_BOTH_EDGES != 0) || filt_q);
    assign eff_dir = dir_s ^ flip;

    always_comb begin
        count_d  = count_q;
        dir_d    = dir_q;
        idle_d   = idle_q;
        moving_d = moving_q;
        if (step) begin
            count_d  = eff_dir ? (count_q - COUNT_W'(1)) : (count_q + COUNT_W'(1));
            dir_d    = eff_dir;
            idle_d   = '0;
            moving_d = 1'b1;
        end else begin
            if (idle_q != IDLE_MAX) begin
                idle_d = idle_q + IW'(1);
            end
            if (idle_d >= IDLE_CLEAR) begin
                moving_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dir_sync_q  <= '0;
            clk_sync_q  <= '0;
            filt_cnt_q  <= '0;
            filt_q      <= 1'b0;
            filt_prev_q <= 1'b0;
            count_q     <= '0;
            dir_q       <= 1'b0;
            moving_q    <= 1'b0;
            idle_q      <= '0;
        end else begin
            dir_sync_q  <= {dir_sync_q[SYNC_STAGES-2:0], dir_raw};
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], step_clk_raw};
            filt_cnt_q  <= filt_cnt_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            count_q     <= count_d;
            dir_q       <= dir_d;
            moving_q    <= moving_d;
            idle_q      <= idle_d;
        end
    end

    assign state.dir    = dir_q;
    assign state.moving = moving_q;
    assign state.count  = count_q;

endmodule

// File: rtl/trackball_decoder.sv
// Atari-style trackball receiver: two axis decoders sharing a post-reset warmup,
// plus a registered CPU snapshot of the selected axis.
//   clk, reset       : system clock, synchronous active-high reset
//   flip             : cocktail flip, inverts count direction on both axes
//   h_dir, h_clk     : horizontal direction level / step clock (asynchronous)
//   v_dir, v_clk     : vertical direction level / step clock (asynchronous)
//   bus              : CPU read port (rd_sel, rd_strobe in; dout out)
//   h_count, v_count : live counters for debug
module trackball_decoder
    import trackball_pkg::*;
#(
    parameter int unsigned SYNC_STAGES      = 2,
    parameter int unsigned FILTER_LEN       = 4,
    parameter int unsigned IDLE_CYCLES      = 1048576,
    parameter int unsigned COUNT_BOTH_EDGES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flip,
    input  logic                  h_dir,
    input  logic                  h_clk,
    input  logic                  v_dir,
    input  logic                  v_clk,
    trackball_decoder_if.slave    bus,
    output logic [COUNT_W-1:0]    h_count,
    output logic [COUNT_W-1:0]    v_count
);

    localparam int unsigned WARM_LOAD = SYNC_STAGES + FILTER_LEN;
    localparam int unsigned WW        = $clog2(WARM_LOAD + 1);

    logic [WW-1:0] warm_q;
    logic          warmup;
    axis_state_t   h_state;
    axis_state_t   v_state;
    logic [7:0]    rd_data;

    assign warmup = (warm_q != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            warm_q <= WW'(WARM_LOAD);
        end else if (warmup) begin
            warm_q <= warm_q - WW'(1);
        end
    end

    trackball_axis #(
        .SYNC_STAGES      (SYNC_STAGES),
        .FILTER_LEN       (FILTER_LEN),
        .IDLE_CYCLES      (IDLE_CYCLES),
        .COUNT_BOTH_EDGES (COUNT_BOTH_EDGES)
    ) u_axis_h (
        .clk          (clk),
        .reset        (reset),
        .warmup       (warmup),
        .flip         (flip),
        .dir_raw      (h_dir),
        .step_clk_raw (h_clk),
        .state        (h_state)
    );

    trackball_axis #(
        .SYNC_STAGES      (SYNC_STAGES),
        .FILTER_LEN       (FILTER_LEN),
        .IDLE_CYCLES      (IDLE_CYCLES),
        .COUNT_BOTH_EDGES (COUNT_BOTH_EDGES)
    ) u_axis_v (
        .clk          (clk),
        .reset        (reset),
        .warmup       (warmup),
        .flip         (flip),
        .dir_raw      (v_dir),
        .step_clk_raw (v_clk),
        .state        (v_state)
    );

    // Snapshot uses registered axis state, so a coincident step reads pre-step.
    always_comb begin
        rd_data = '0;
        case (bus.rd_sel)
            AXIS_H: rd_data = pack_dout(h_state);
            AXIS_V: rd_data = pack_dout(v_state);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.dout <= '0;
        end else if (bus.rd_strobe) begin
            bus.dout <= rd_data;
        end
    end

    assign h_count = h_state.count;
    assign v_count = v_state.count;

endmodule

// File: tb/tb_trackball_decoder.sv
// Directed bench for trackball_decoder. u_dut uses default parameters; u_dut_idle
// shares the same inputs but has IDLE_CYCLES=16 so the moving timeout is reachable.
module tb_trackball_decoder;

    logic       clk;
    logic       reset;
    logic       flip;
    logic       h_dir;
    logic       h_clk;
    logic       v_dir;
    logic       v_clk;
    logic [3:0] h_count, v_count;
    logic [3:0] h_count2, v_count2;

    int n_cmp;
    int n_bad;

    trackball_decoder_if bus1 ();
    trackball_decoder_if bus2 ();

    trackball_decoder u_dut (
        .clk     (clk),
        .reset   (reset),
        .flip    (flip),
        .h_dir   (h_dir),
        .h_clk   (h_clk),
        .v_dir   (v_dir),
        .v_clk   (v_clk),
        .bus     (bus1),
        .h_count (h_count),
        .v_count (v_count)
    );

    trackball_decoder #(
        .IDLE_CYCLES (16)
    ) u_dut_idle (
        .clk     (clk),
        .reset   (reset),
        .flip    (flip),
        .h_dir   (h_dir),
        .h_clk   (h_clk),
        .v_dir   (v_dir),
        .v_clk   (v_clk),
        .bus     (bus2),
        .h_count (h_count2),
        .v_count (v_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n active edges, then settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(10);
    endtask

    task automatic step_h(input int n);
        for (int i = 0; i < n; i++) begin
            h_clk = 1'b1;
            tick(20);
            h_clk = 1'b0;
            tick(20);
        end
    endtask

    task automatic step_v(input int n);
        for (int i = 0; i < n; i++) begin
            v_clk = 1'b1;
            tick(20);
            v_clk = 1'b0;
            tick(20);
        end
    endtask

    task automatic read1(input logic sel);
        bus1.rd_sel    = sel;
        bus1.rd_strobe = 1'b1;
        tick(1);
        bus1.rd_strobe = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (h_count !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_h_count: got %h want %h", h_count, 4'h0);
        end
        n_cmp++;
        if (v_count !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_v_count: got %h want %h", v_count, 4'h0);
        end
        n_cmp++;
        if (bus1.dout !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_dout: got %h want %h", bus1.dout, 8'h00);
        end
    endtask

    task automatic test_count_up();
        do_reset();
        h_dir = 1'b0;
        flip  = 1'b0;
        step_h(5);
        n_cmp++;
        if (h_count !== 4'h5) begin
            n_bad++;
            $display("FAIL up_h_count: got %h want %h", h_count, 4'h5);
        end
        read1(1'b0);
        n_cmp++;
        if (bus1.dout !== 8'h45) begin
            n_bad++;
            $display("FAIL up_dout: got %h want %h", bus1.dout, 8'h45);
        end
        // Select the other axis without a strobe; dout must hold.
        bus1.rd_sel = 1'b1;
        tick(5);
        n_cmp++;
        if (bus1.dout !== 8'h45) begin
            n_bad++;
            $display("FAIL up_dout_hold: got %h want %h", bus1.dout, 8'h45);
        end
    endtask

    task automatic test_wrap_down();
        do_reset();
        h_dir = 1'b0;
        step_h(2);
        h_dir = 1'b1;
        step_h(6);
        n_cmp++;
        if (h_count !== 4'hC) begin
            n_bad++;
            $display("FAIL wrap_h_count: got %h want %h", h_count, 4'hC);
        end
        read1(1'b0);
        n_cmp++;
        if (bus1.dout !== 8'hCC) begin
            n_bad++;
            $display("FAIL wrap_dout: got %h want %h", bus1.dout, 8'hCC);
        end
        h_dir = 1'b0;
    endtask

    task automatic test_flip_glitch_latency();
        flip = 1'b1;
        do_reset();
        h_dir = 1'b0;
        step_h(3);
        n_cmp++;
        if (h_count !== 4'hD) begin
            n_bad++;
            $display("FAIL flip_h_count: got %h want %h", h_count, 4'hD);
        end
        // 3-cycle pulse is shorter than the filter window.
        h_clk = 1'b1;
        tick(3);
        h_clk = 1'b0;
        tick(20);
        n_cmp++;
        if (h_count !== 4'hD) begin
            n_bad++;
            $display("FAIL glitch_h_count: got %h want %h", h_count, 4'hD);
        end
        // Held rise sampled at edge 0 must land exactly at edge 6.
        h_clk = 1'b1;
        tick(6);
        n_cmp++;
        if (h_count !== 4'hD) begin
            n_bad++;
            $display("FAIL latency_edge5: got %h want %h", h_count, 4'hD);
        end
        tick(1);
        n_cmp++;
        if (h_count !== 4'hC) begin
            n_bad++;
            $display("FAIL latency_edge6: got %h want %h", h_count, 4'hC);
        end
        h_clk = 1'b0;
        tick(20);
        flip = 1'b0;
    endtask

    task automatic test_warmup();
        h_clk = 1'b1;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(30);
        n_cmp++;
        if (h_count !== 4'h0) begin
            n_bad++;
            $display("FAIL warmup_no_count: got %h want %h", h_count, 4'h0);
        end
        h_clk = 1'b0;
        tick(20);
        h_clk = 1'b1;
        tick(20);
        n_cmp++;
        if (h_count !== 4'h1) begin
            n_bad++;
            $display("FAIL warmup_first_edge: got %h want %h", h_count, 4'h1);
        end
        h_clk = 1'b0;
        tick(20);
    endtask

    task automatic test_read_collision();
        do_reset();
        v_dir = 1'b0;
        step_v(7);
        v_clk = 1'b1;
        tick(6);
        n_cmp++;
        if (v_count !== 4'h7) begin
            n_bad++;
            $display("FAIL collide_pre: got %h want %h", v_count, 4'h7);
        end
        bus1.rd_sel    = 1'b1;
        bus1.rd_strobe = 1'b1;
        tick(1);
        bus1.rd_strobe = 1'b0;
        n_cmp++;
        if (bus1.dout !== 8'h47) begin
            n_bad++;
            $display("FAIL collide_dout: got %h want %h", bus1.dout, 8'h47);
        end
        n_cmp++;
        if (v_count !== 4'h8) begin
            n_bad++;
            $display("FAIL collide_v_count: got %h want %h", v_count, 4'h8);
        end
        read1(1'b1);
        n_cmp++;
        if (bus1.dout !== 8'h48) begin
            n_bad++;
            $display("FAIL collide_after: got %h want %h", bus1.dout, 8'h48);
        end
        v_clk = 1'b0;
        tick(20);
    endtask

    task automatic test_idle();
        do_reset();
        h_dir = 1'b0;
        h_clk = 1'b1;
        tick(7);  // step lands at edge 6 (S)
        n_cmp++;
        if (h_count2 !== 4'h1) begin
            n_bad++;
            $display("FAIL idle_step: got %h want %h", h_count2, 4'h1);
        end
        tick(14); // now just past S+14
        bus2.rd_sel    = 1'b0;
        bus2.rd_strobe = 1'b1;
        tick(1);  // edge S+15 captures the still-moving state
        n_cmp++;
        if (bus2.dout !== 8'h41) begin
            n_bad++;
            $display("FAIL idle_still_moving: got %h want %h", bus2.dout, 8'h41);
        end
        tick(1);  // edge S+16 captures moving cleared at S+15
        bus2.rd_strobe = 1'b0;
        n_cmp++;
        if (bus2.dout !== 8'h01) begin
            n_bad++;
            $display("FAIL idle_stopped: got %h want %h", bus2.dout, 8'h01);
        end
        read1(1'b0);
        n_cmp++;
        if (bus1.dout !== 8'h41) begin
            n_bad++;
            $display("FAIL idle_default_moving: got %h want %h", bus1.dout, 8'h41);
        end
        h_clk = 1'b0;
        tick(20);
    endtask

    task automatic test_concurrent_and_reset();
        do_reset();
        h_dir = 1'b0;
        v_dir = 1'b1;
        for (int i = 0; i < 2; i++) begin
            h_clk = 1'b1;
            v_clk = 1'b1;
            tick(20);
            h_clk = 1'b0;
            v_clk = 1'b0;
            tick(20);
        end
        n_cmp++;
        if (h_count !== 4'h2) begin
            n_bad++;
            $display("FAIL both_h_count: got %h want %h", h_count, 4'h2);
        end
        n_cmp++;
        if (v_count !== 4'hE) begin
            n_bad++;
            $display("FAIL both_v_count: got %h want %h", v_count, 4'hE);
        end
        read1(1'b1);
        n_cmp++;
        if (bus1.dout !== 8'hCE) begin
            n_bad++;
            $display("FAIL both_dout: got %h want %h", bus1.dout, 8'hCE);
        end
        reset = 1'b1;
        tick(1);
        n_cmp++;
        if ({h_count, v_count, bus1.dout} !== 16'h0000) begin
            n_bad++;
            $display("FAIL mid_reset: got %h want %h", {h_count, v_count, bus1.dout},
                     16'h0000);
        end
        reset = 1'b0;
        v_dir = 1'b0;
        tick(10);
    endtask

    initial begin
        n_cmp          = 0;
        n_bad          = 0;
        reset          = 1'b1;
        flip           = 1'b0;
        h_dir          = 1'b0;
        h_clk          = 1'b0;
        v_dir          = 1'b0;
        v_clk          = 1'b0;
        bus1.rd_sel    = 1'b0;
        bus1.rd_strobe = 1'b0;
        bus2.rd_sel    = 1'b0;
        bus2.rd_strobe = 1'b0;

        test_reset();
        test_count_up();
        test_wrap_down();
        test_flip_glitch_latency();
        test_warmup();
        test_read_collision();
        test_idle();
        test_concurrent_and_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/trackball_decoder.md
Name: trackball_decoder

Overview:
- Game-side receiver for Atari-style trackball signals: per-axis direction level plus a clock that toggles once per motion step.
- Synchronises and deglitches both axes, then counts motion steps in 4-bit up/down counters, emulating the LS169 pair on the board.
- Presents CPU-readable snapshots in the input-port byte format.
- Sits between the trackball emulator outputs (or real cabinet pins) and the CPU input mux.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on each of the four inputs (minimum 2).
- FILTER_LEN, 4, consecutive cycles a synchronised clock level must be stable before the filtered level changes (minimum 1).
- IDLE_CYCLES, 1048576, cycles without a counted step before an axis moving flag clears.
- COUNT_BOTH_EDGES, 0, 0 = count filtered rising edges only; 1 = count rising and falling edges.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- flip  in  1  cocktail flip; inverts count direction on both axes
- h_dir  in  1  horizontal direction level (1 = negative)
- h_clk  in  1  horizontal step clock
- v_dir  in  1  vertical direction level (1 = negative)
- v_clk  in  1  vertical step clock
- rd_sel  in  1  0 = horizontal axis, 1 = vertical axis
- rd_strobe  in  1  single-cycle read request
- dout  out  8  snapshot {dir, moving, 2'b00, count[3:0]}
- h_count  out  4  live horizontal counter (debug)
- v_count  out  4  live vertical counter (debug)

Behaviour:
- Reset: counts, dir, moving, dout, synchroniser flops, filter counters and filtered levels all go to 0. The warmup counter loads SYNC_STAGES+FILTER_LEN.
- The clock is in one domain; reset is synchronous, active-high. All four inputs are asynchronous and pass through SYNC_STAGES flops. Dir and clk of an axis use equal sync depth, so they stay aligned.
- Filter:
  - A per-axis counter increments while the synchronised clk differs from the filtered level, and clears while they are equal.
  - When the counter reaches FILTER_LEN-1 and the inputs still differ, the filtered level flips and the counter clears.
  - Pulses shorter than FILTER_LEN cycles are discarded.
- Step event: asserted for one cycle on a filtered rising edge, or on either filtered edge if COUNT_BOTH_EDGES=1.
- Latency: an input change first sampled at edge 0 and held updates the count at edge SYNC_STAGES+FILTER_LEN (6 with defaults).
- Count on a step event:
  - The effective direction is synced dir XOR flip, sampled in the same cycle as the step event.
  - Effective direction 0: count+1. Effective direction 1: count-1.
  - Wraps modulo 16 (F+1→0, 0-1→F).
  - The axis dir register latches the effective direction on every step.
- Warmup:
  - While the warmup counter is nonzero, filtered levels track inputs but step events are suppressed.
  - The counter decrements each cycle.
  - This prevents a spurious count when inputs are high as reset releases.
- Idle:
  - A per-axis idle counter, saturating at IDLE_CYCLES, is cleared on each step and increments otherwise.
  - moving=1 on a step. moving=0 when the idle counter reaches IDLE_CYCLES-1.
- Read:
  - rd_strobe at edge N loads dout with the selected axis's {dir, moving, 00, count} as registered before edge N. The value is visible after edge N.
  - dout holds until the next strobe.
  - When a strobe coincides with a step on the same axis, the snapshot is the pre-step value and the step is still applied.
- Simultaneous h and v steps are independent; no arbitration is needed.
- Reset mid-operation: all state clears on the next edge, and warmup restarts.
- No handshake back-pressure exists; steps can never be lost except those suppressed by the filter or warmup.

Decomposition:
- Package trackball_pkg holds:
  - AXIS_H = 1'b0, AXIS_V = 1'b1
  - dout bit indices DOUT_DIR = 7, DOUT_MOVING = 6, DOUT_COUNT_LSB = 0
  - COUNT_W = 4
- Sub-module trackball_axis: synchroniser, filter, edge detect, up/down counter and idle timer for one axis. It is instantiated twice and shares the warmup enable.
- The top level holds the warmup counter, the read mux and the dout register.

Test Plan:
- Reset, then 5 h_clk rising edges with h_dir=0, flip=0, each level held 20 cycles → h_count=5. Strobe with rd_sel=0 → dout=8'h45.
- h_dir=1, 6 rising edges from count 2 → count wraps to 4'hC. A read gives dout=8'hCC (dir=1, moving=1).
- flip=1, h_dir=0, 3 steps from 0 → count=4'hD. Then a 3-cycle h_clk glitch → no change. Latency check: a held change sampled at edge 0 updates the count at edge 6.
- h_clk=1 held through reset release → no count after warmup (count stays 0). The first genuine 0→1 edge afterwards → count=1.
- rd_strobe in the same cycle as a v step (count 7→8) → dout low nibble=7, and v_count=8 on the next edge.
- With IDLE_CYCLES=16, a step then 16 quiet cycles → moving drops after cycle 15 and a read returns bit 6=0. Concurrent h and v steps both count.
